conv2d_engine: RTL and testbench
================================

// Module: conv2d_engine
// PURPOSE
//  Streaming 5x5 2-D correlation engine over a 50x50 image of 12-bit unsigned pixels held in
//  external single-port memory. On start it reads pixels via ReadAddress/d_in (combinational
//  read, data valid in the same cycle) and writes one 20-bit result per pixel via
//  WriteAddress/d_out/WriteEnable. Zero padding keeps output size equal to input (50x50).
// PARAMETERS
//  IMG_W   50  image width (pixels)
//  IMG_H   50  image height (pixels)
//  K       5   kernel side length (odd)
//  PIX_W   12  input pixel width, unsigned
//  COEF_W  8   coefficient width, two's complement
//  OUT_W   20  output width (PIX_W+COEF_W)
//  ADDR_W  17  read/write address width
// PORTS
//  clk           in   1              rising-edge clock
//  rst           in   1              asynchronous, active-high reset
//  start         in   1              one-cycle pulse; begins a frame when idle
//  f_coeff       in   K*K*COEF_W=200 kernel; coef k=r*K+c at bits [8k+7:8k]; k=0 top-left
//  d_in          in   PIX_W          pixel at ReadAddress, valid in the same cycle
//  ReadAddress   out  ADDR_W         row*IMG_W+col of pixel being fetched
//  WriteAddress  out  ADDR_W         row*IMG_W+col of result on d_out
//  d_out         out  OUT_W          result, low 20 bits of the two's-complement sum
//  ready         out  1              1 = idle/done, 0 = frame in progress
//  WriteEnable   out  1              one-cycle write strobe
// BEHAVIOUR
//  - Reset: ReadAddress=0, WriteAddress=0, d_out=0, WriteEnable=0, ready=1, window=0, FSM IDLE.
//  - All outputs registered. f_coeff is sampled at start and held for the whole frame.
//  - out(r,c) = sum over i,j in 0..4 of coef[i*5+j] * pix(r+i-2, c+j-2).
//    Pixels outside the image read as 0. Pixels are zero-extended; coefs are sign-extended.
//    Full-precision signed accumulation; d_out = sum[19:0] (wraps, no saturation).
//  - Window: 5x5 register array. Each column load shifts the window left by one column and
//    takes 5 cycles, one pixel per cycle, top row first.
//    d_in is captured at the rising edge that ends the cycle in which ReadAddress is driven.
//    An out-of-range row or column inserts 0 and still costs its cycle; ReadAddress holds
//    its last value during such cycles.
//  - FSM: IDLE -(start)-> PREFILL -> LOAD -> WRITE -> LOAD ... -> DONE -> IDLE.
//    PREFILL: per row, load columns -2,-1,0,1 (20 cycles).
//    LOAD: load column c+2 (5 cycles). WRITE starts on the cycle after the 5th pixel.
//  - WriteEnable: high for exactly 1 cycle per pixel, with d_out and WriteAddress valid.
//    d_out and WriteAddress hold their values until the next write; WRITE then starts the
//    next LOAD in the same cycle.
//  - Order: raster, row 0 col 0 first, address 0..2499. Each row costs 20 + 50*5 = 270 cycles.
//    A frame completes within 13,510 cycles of start.
//  - ready falls the cycle after an accepted start. It rises the cycle after the final write
//    (address 2499). start while ready=0 is ignored.
//  - Async rst mid-frame aborts immediately to the reset state; a new start is needed.
// STRUCTURE
//  - Package conv2d_pkg: IMG_W, IMG_H, K, widths, FSM state enum, coef/pixel typedefs.
//  - Sub-module conv2d_mac: combinational 25-tap signed multiply and adder tree.
//    Inputs: window and coefs. Output: OUT_W result. Top holds the FSM, counters,
//    address generation and window registers.
// TESTING
//  1 Reset: assert rst mid-frame -> all outputs at reset values; ready=1; no WriteEnable.
//  2 Identity kernel (coef12=1, rest 0), image pix=addr%4096 -> d_out[a]=a for all 2500
//    addresses, each written exactly once, in order.
//  3 All-ones kernel, constant image 1 -> corners 9, edges (non-corner) 15, one-in-from-edge
//    (non-corner) 20, interior 25 (zero-padding check).
//  4 Signed kernel 200'h050000000400fffeff00000000000000010201000200000001 on random image
//    -> matches golden model (low 20 bits). Sum of 25*4095*(-128) must wrap correctly.
//  5 Timing: start pulse -> ready low next cycle; 2500 WriteEnable pulses;
//    ready high within 13,510 cycles. A start pulse while busy has no effect.
//  6 Back-to-back frames: second start after ready=1 with a new f_coeff -> second frame
//    uses the new coefs. Output is correct.

Source files
------------

// File: rtl/conv2d_pkg.sv
// Shared definitions for the 5x5 streaming correlation engine.
//   Image geometry, data widths, FSM state encoding and pixel/coef types.
package conv2d_pkg;
  localparam int IMG_W  = 50;
  localparam int IMG_H  = 50;
  localparam int K      = 5;
  localparam int PIX_W  = 12;
  localparam int COEF_W = 8;
  localparam int OUT_W  = PIX_W + COEF_W;
  localparam int ADDR_W = 17;
  localparam int NTAP   = K * K;
  localparam int HALF   = K / 2;

  typedef logic        [PIX_W-1:0]  pix_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;
endpackage

// File: rtl/conv2d_mac.sv
// Combinational 25-tap multiply-accumulate.
//   win    : K*K unsigned pixels, tap k=r*K+c at [k*PIX_W +: PIX_W]
//   coef   : K*K signed coefficients, tap k at [k*COEF_W +: COEF_W]
//   result : low OUT_W bits of the full-precision signed sum
module conv2d_mac
  import conv2d_pkg::*;
(
  input  logic [NTAP*PIX_W-1:0]  win,
  input  logic [NTAP*COEF_W-1:0] coef,
  output logic [OUT_W-1:0]       result
);
  localparam int ACC_W = PIX_W + COEF_W + $clog2(NTAP) + 1;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] pe;
  logic signed [ACC_W-1:0] ce;
  coef_t                   c;

  always_comb begin
    acc = '0;
    pe  = '0;
    ce  = '0;
    c   = '0;
    for (int unsigned k = 0; k < NTAP; k++) begin
      pe  = ACC_W'(win[k*PIX_W +: PIX_W]);      // zero-extend pixel
      c   = coef[k*COEF_W +: COEF_W];
      ce  = ACC_W'(c);                          // sign-extend coefficient
      acc = acc + pe * ce;
    end
    result = acc[OUT_W-1:0];
  end
endmodule

// File: rtl/conv2d_engine.sv
// Streaming 5x5 correlation over a 50x50 image in external memory, zero padded.
//   clk, rst (async, active high), start (pulse, accepted when idle)
//   f_coeff      : kernel, sampled at start
//   d_in         : pixel at ReadAddress, same-cycle combinational read
//   ReadAddress  : address of the pixel captured at the end of this cycle
//   WriteAddress, d_out, WriteEnable : one registered write per output pixel
//   ready        : high when idle/done
module conv2d_engine
  import conv2d_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K*K*COEF_W-1:0]  f_coeff,
  input  logic [PIX_W-1:0]       d_in,
  output logic [ADDR_W-1:0]      ReadAddress,
  output logic [ADDR_W-1:0]      WriteAddress,
  output logic [OUT_W-1:0]       d_out,
  output logic                   ready,
  output logic                   WriteEnable
);
  localparam logic signed [6:0] COL_FIRST = 7'(-HALF);
  localparam logic signed [6:0] COL_LAST  = 7'(IMG_W - 1 + HALF);
  localparam logic signed [6:0] COL_WR    = 7'(HALF);

  state_t                  state, state_nx;
  logic [2:0]              ld_row, ld_row_nx;
  logic signed [6:0]       ld_col, ld_col_nx;
  logic [5:0]              out_row, out_row_nx;
  logic [ADDR_W-1:0]       wr_cnt;
  logic                    pix_vld;
  pix_t                    win [K][K];
  logic [NTAP*PIX_W-1:0]   win_flat;
  logic [NTAP*COEF_W-1:0]  coef_q;
  logic [OUT_W-1:0]        mac_out;
  logic                    load_en, load_nx, fetch_ok;
  logic signed [7:0]       f_row, f_col;
  logic [ADDR_W-1:0]       fetch_addr;

  // The WRITE cycle also fetches the first pixel of the next column, except
  // after the last output row, where it only drains the final result.
  assign load_en = (state == S_PREFILL) || (state == S_LOAD) ||
                   ((state == S_WRITE) && (out_row != 6'(IMG_H)));

  always_comb begin
    ld_row_nx  = ld_row;
    ld_col_nx  = ld_col;
    out_row_nx = out_row;
    if (state == S_IDLE) begin
      if (start) begin
        ld_row_nx  = '0;
        ld_col_nx  = COL_FIRST;
        out_row_nx = '0;
      end
    end else if (load_en) begin
      if (ld_row == 3'(K-1)) begin
        ld_row_nx = '0;
        if (ld_col == COL_LAST) begin
          ld_col_nx  = COL_FIRST;
          out_row_nx = out_row + 6'd1;
        end else begin
          ld_col_nx = ld_col + 7'sd1;
        end
      end else begin
        ld_row_nx = ld_row + 3'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_PREFILL;
      S_PREFILL, S_LOAD, S_WRITE: begin
        if (!load_en)                                        state_nx = S_DONE;
        else if ((ld_row == 3'(K-1)) && (ld_col >= COL_WR))  state_nx = S_WRITE;
        else if (ld_col_nx >= COL_WR)                        state_nx = S_LOAD;
        else                                                 state_nx = S_PREFILL;
      end
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Address for the pixel loaded next cycle is registered one cycle ahead so
  // ReadAddress is stable during the cycle whose closing edge captures d_in.
  always_comb begin
    load_nx    = (state_nx == S_PREFILL) || (state_nx == S_LOAD) ||
                 ((state_nx == S_WRITE) && (out_row_nx != 6'(IMG_H)));
    f_row      = 8'(out_row_nx) + 8'(ld_row_nx) - 8'(HALF);
    f_col      = {ld_col_nx[6], ld_col_nx};
    fetch_ok   = load_nx && (f_row >= 0) && (f_row < IMG_H) &&
                 (f_col >= 0) && (f_col < IMG_W);
    fetch_addr = ADDR_W'(f_row * IMG_W + f_col);
  end

  always_comb begin
    win_flat = '0;
    for (int unsigned i = 0; i < K; i++)
      for (int unsigned j = 0; j < K; j++)
        win_flat[(i*K+j)*PIX_W +: PIX_W] = win[i][j];
  end

  conv2d_mac u_mac (
    .win    (win_flat),
    .coef   (coef_q),
    .result (mac_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadAddress  <= '0;
      WriteAddress <= '0;
      d_out        <= '0;
      WriteEnable  <= 1'b0;
      ready        <= 1'b1;
      ld_row       <= '0;
      ld_col       <= '0;
      out_row      <= '0;
      wr_cnt       <= '0;
      pix_vld      <= 1'b0;
      coef_q       <= '0;
      for (int unsigned i = 0; i < K; i++)
        for (int unsigned j = 0; j < K; j++)
          win[i][j] <= '0;
    end else begin
      WriteEnable <= 1'b0;
      ld_row      <= ld_row_nx;
      ld_col      <= ld_col_nx;
      out_row     <= out_row_nx;
      pix_vld     <= fetch_ok;
      if (fetch_ok) ReadAddress <= fetch_addr;
      if ((state == S_IDLE) && start) begin
        coef_q <= f_coeff;
        ready  <= 1'b0;
        wr_cnt <= '0;
      end
      // Each captured pixel shifts only its own window row, so after five
      // captures the whole window has moved left by one column.
      if (load_en) begin
        for (int unsigned j = 0; j < K-1; j++)
          win[ld_row][j] <= win[ld_row][j+1];
        win[ld_row][K-1] <= pix_vld ? d_in : '0;
      end
      if (state == S_WRITE) begin
        d_out        <= mac_out;
        WriteAddress <= wr_cnt;
        WriteEnable  <= 1'b1;
        wr_cnt       <= wr_cnt + 1'b1;
      end
      if (state == S_DONE) ready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv2d_engine.sv
module tb_conv2d_engine;
  import conv2d_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [K*K*COEF_W-1:0] f_coeff;
  logic [PIX_W-1:0]      d_in;
  logic [ADDR_W-1:0]     ReadAddress;
  logic [ADDR_W-1:0]     WriteAddress;
  logic [OUT_W-1:0]      d_out;
  logic                  ready;
  logic                  WriteEnable;

  conv2d_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .f_coeff      (f_coeff),
    .d_in         (d_in),
    .ReadAddress  (ReadAddress),
    .WriteAddress (WriteAddress),
    .d_out        (d_out),
    .ready        (ready),
    .WriteEnable  (WriteEnable)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [2500];
  assign d_in = (ReadAddress < 17'd2500) ? mem[ReadAddress[11:0]] : 12'd0;

  logic [19:0] res    [2500];
  int          wcount [2500];
  int          nwr;
  int          seq_bad;

  always @(negedge clk) begin
    if (!rst && WriteEnable) begin
      if (WriteAddress < 17'd2500) begin
        res[WriteAddress[11:0]]    = d_out;
        wcount[WriteAddress[11:0]] = wcount[WriteAddress[11:0]] + 1;
      end
      if (WriteAddress != 17'(nwr)) seq_bad++;
      nwr++;
    end
  end

  int tests  = 0;
  int failed = 0;
  logic [199:0] gcoef;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int golden(input int r, input int c);
    int s = 0;
    int rr, cc, p;
    logic signed [7:0] w;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        rr = r + i - 2;
        cc = c + j - 2;
        p  = (rr >= 0 && rr < 50 && cc >= 0 && cc < 50) ? int'(mem[rr*50+cc]) : 0;
        w  = gcoef[8*(i*5+j) +: 8];
        s  = s + p * int'(w);
      end
    return s;
  endfunction

  task automatic clear_capture();
    for (int a = 0; a < 2500; a++) begin
      wcount[a] = 0;
      res[a]    = '0;
    end
    nwr     = 0;
    seq_bad = 0;
  endtask

  task automatic run_frame(input logic [199:0] k, input bit poke_busy, input string tag);
    int cyc;
    gcoef   = k;
    f_coeff = k;
    clear_capture();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_ready_low"}, {31'b0, ready}, 32'd0);
    f_coeff = ~k;  // must be ignored: coefs are held from start
    cyc = 1;
    while (ready !== 1'b1 && cyc < 14000) begin
      @(negedge clk);
      cyc++;
      start = (poke_busy && cyc == 1000);
      if (poke_busy && cyc == 1010) chk({tag, "_busy_ready"}, {31'b0, ready}, 32'd0);
    end
    start = 1'b0;
    chk({tag, "_ready_in_time"}, {31'b0, (ready === 1'b1 && cyc <= 13510)}, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int bad = 0;
    logic [31:0] e;
    chk({tag, "_nwrites"}, nwr, 32'd2500);
    chk({tag, "_order"}, seq_bad, 32'd0);
    for (int a = 0; a < 2500; a++) if (wcount[a] != 1) bad++;
    chk({tag, "_write_once"}, bad, 32'd0);
    for (int a = 0; a < 2500; a++) begin
      e = golden(a / 50, a % 50);
      chk($sformatf("%s[%0d]", tag, a), {12'b0, res[a]}, {12'b0, e[19:0]});
    end
  endtask

  logic [199:0] k_id, k_ones, k_neg, k_sgn;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    f_coeff = '0;
    k_id    = 200'd1 << 96;
    k_ones  = '0;
    k_neg   = '0;
    for (int i = 0; i < 25; i++) begin
      k_ones[8*i +: 8] = 8'h01;
      k_neg[8*i +: 8]  = 8'h80;
    end
    k_sgn = 200'h050000000400fffeff00000000000000010201000200000001;
    for (int a = 0; a < 2500; a++) mem[a] = 12'(a % 4096);
    clear_capture();

    // 1: reset values, then reset mid-frame
    repeat (2) @(negedge clk);
    chk("rst_raddr", 32'(ReadAddress), 32'd0);
    chk("rst_waddr", 32'(WriteAddress), 32'd0);
    chk("rst_dout", 32'(d_out), 32'd0);
    chk("rst_we", {31'b0, WriteEnable}, 32'd0);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    rst = 1'b0;
    f_coeff = k_id;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (700) @(negedge clk);
    chk("mid_busy", {31'b0, ready}, 32'd0);
    chk("mid_wr_started", {31'b0, (nwr > 0)}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_raddr", 32'(ReadAddress), 32'd0);
    chk("abort_waddr", 32'(WriteAddress), 32'd0);
    chk("abort_dout", 32'(d_out), 32'd0);
    chk("abort_we", {31'b0, WriteEnable}, 32'd0);
    chk("abort_ready", {31'b0, ready}, 32'd1);
    @(negedge clk) rst = 1'b0;
    clear_capture();
    repeat (300) @(negedge clk);
    chk("abort_no_writes", nwr, 32'd0);
    chk("abort_stay_ready", {31'b0, ready}, 32'd1);

    // 2 + 5: identity kernel with a start pulse while busy
    run_frame(k_id, 1'b1, "ident");
    check_frame("ident");
    chk("ident_a0", {12'b0, res[0]}, 32'd0);
    chk("ident_a1234", {12'b0, res[1234]}, 32'd1234);
    chk("ident_a2499", {12'b0, res[2499]}, 32'd2499);

    // 3: all-ones kernel on constant image exposes zero padding
    for (int a = 0; a < 2500; a++) mem[a] = 12'd1;
    run_frame(k_ones, 1'b0, "ones");
    check_frame("ones");
    chk("ones_corner00", {12'b0, res[0]}, 32'd9);
    chk("ones_corner4949", {12'b0, res[2499]}, 32'd9);
    chk("ones_edge_0_25", {12'b0, res[25]}, 32'd15);
    chk("ones_edge_25_0", {12'b0, res[1250]}, 32'd15);
    chk("ones_in1_1_25", {12'b0, res[75]}, 32'd20);
    chk("ones_in1_25_48", {12'b0, res[1298]}, 32'd20);
    chk("ones_diag_1_1", {12'b0, res[51]}, 32'd16);
    chk("ones_int_25_25", {12'b0, res[1275]}, 32'd25);

    // 4: signed kernel on random image
    for (int a = 0; a < 2500; a++) mem[a] = 12'($urandom_range(0, 4095));
    run_frame(k_sgn, 1'b0, "sgn");
    check_frame("sgn");

    // 6: back-to-back frame with new coefs, extreme negative sum wraps
    for (int a = 0; a < 2500; a++) mem[a] = 12'hFFF;
    run_frame(k_neg, 1'b0, "neg");
    check_frame("neg");
    chk("neg_int_25_25", {12'b0, res[1275]}, 32'd527488);
    chk("neg_corner00", {12'b0, res[0]}, 32'd525440);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
